// File: rtl/wrap_pkg.sv
// Shared definitions for the policy write/read-back checker: data width,
// default geometry, controller state encoding and the expected-word helper.
package wrap_pkg;

  localparam int DATA_W        = 32;
  localparam int DEF_N_ENTRIES = 4;
  localparam logic [DATA_W-1:0] DEF_POLICY_BASE = 32'hC0DE_0000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    CHECK   = 3'd5
  } state_t;

  function automatic logic [DATA_W-1:0] policy_word(input logic [DATA_W-1:0] base,
                                                    input logic [DATA_W-1:0] idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/policy_regs.sv
// Policy register file with valid/ready ports. Ready answers one cycle after
// valid rises; writes land on the handshake cycle, reads return registered data.
module policy_regs
  import wrap_pkg::*;
#(
  parameter int N_ENTRIES = DEF_N_ENTRIES,
  parameter int IDX_W     = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic              asclk,
  input  logic              aresetn,
  input  logic              wr_valid,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_valid,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0]    entry_reg [N_ENTRIES];
  logic [N_ENTRIES-1:0] wr_hit;
  logic                 wr_ready_reg;
  logic                 rd_ready_reg;
  logic [DATA_W-1:0]    rd_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_ENTRIES; gi++) begin : g_hit
      assign wr_hit[gi] = wr_valid && wr_ready_reg && (wr_addr == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge asclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < N_ENTRIES; i++) entry_reg[i] <= '0;
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (wr_hit[i]) entry_reg[i] <= wr_data;
      end
    end
  end

  // Ready pulses for exactly one cycle per request, so each valid phase is two cycles.
  always_ff @(posedge asclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ready_reg <= 1'b0;
      rd_ready_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      wr_ready_reg <= wr_valid && !wr_ready_reg;
      rd_ready_reg <= rd_valid && !rd_ready_reg;
      if (rd_valid && !rd_ready_reg) rd_data_reg <= entry_reg[rd_addr];
    end
  end

  assign wr_ready = wr_ready_reg;
  assign rd_ready = rd_ready_reg;
  assign rd_data  = rd_data_reg;

endmodule

// File: rtl/wrap.sv
// Policy controller: edge-detects write/read requests, writes the expected
// pattern into policy_regs, reads it back and reports match or mismatch.
module wrap
  import wrap_pkg::*;
#(
  parameter int                N_ENTRIES   = DEF_N_ENTRIES,
  parameter logic [DATA_W-1:0] POLICY_BASE = DEF_POLICY_BASE
) (
  input  logic asclk,
  input  logic aresetn,
  input  logic start_w,
  input  logic start_r,
  output logic check_policy,
  output logic check_false_policy
);

  localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  index_reg, index_next;
  logic              mismatch_reg, mismatch_next;
  logic              check_policy_reg, check_policy_next;
  logic              check_false_reg, check_false_next;
  logic              start_w_reg, start_r_reg, armed_reg;
  logic              edge_w, edge_r;
  logic              wr_valid, wr_ready, rd_valid, rd_ready;
  logic [DATA_W-1:0] rd_data, expected_word;

  // armed_reg masks the first cycle after reset so held-high levels never count.
  assign edge_w = armed_reg && start_w && !start_w_reg;
  assign edge_r = armed_reg && start_r && !start_r_reg;

  assign expected_word = policy_word(POLICY_BASE, DATA_W'(index_reg));
  assign wr_valid      = (state_reg == WR_REQ) || (state_reg == WR_WAIT);
  assign rd_valid      = (state_reg == RD_REQ) || (state_reg == RD_WAIT);

  policy_regs #(
    .N_ENTRIES (N_ENTRIES),
    .IDX_W     (IDX_W)
  ) u_regs (
    .asclk    (asclk),
    .aresetn  (aresetn),
    .wr_valid (wr_valid),
    .wr_addr  (index_reg),
    .wr_data  (expected_word),
    .wr_ready (wr_ready),
    .rd_valid (rd_valid),
    .rd_addr  (index_reg),
    .rd_ready (rd_ready),
    .rd_data  (rd_data)
  );

  always_ff @(posedge asclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg        <= IDLE;
      index_reg        <= '0;
      mismatch_reg     <= 1'b0;
      check_policy_reg <= 1'b0;
      check_false_reg  <= 1'b0;
      start_w_reg      <= 1'b0;
      start_r_reg      <= 1'b0;
      armed_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      index_reg        <= index_next;
      mismatch_reg     <= mismatch_next;
      check_policy_reg <= check_policy_next;
      check_false_reg  <= check_false_next;
      start_w_reg      <= start_w;
      start_r_reg      <= start_r;
      armed_reg        <= 1'b1;
    end
  end

  always_comb begin
    state_next        = state_reg;
    index_next        = index_reg;
    mismatch_next     = mismatch_reg;
    check_policy_next = check_policy_reg;
    check_false_next  = check_false_reg;
    case (state_reg)
      IDLE: begin
        // Write wins when both requests rise together; the read is dropped.
        if (edge_w || edge_r) begin
          state_next        = edge_w ? WR_REQ : RD_REQ;
          index_next        = '0;
          mismatch_next     = 1'b0;
          check_policy_next = 1'b0;
          check_false_next  = 1'b0;
        end
      end
      WR_REQ: state_next = WR_WAIT;
      WR_WAIT: begin
        if (wr_ready) begin
          index_next = index_reg + IDX_W'(1);
          state_next = (index_reg < LAST_IDX) ? WR_REQ : IDLE;
        end
      end
      RD_REQ: state_next = RD_WAIT;
      RD_WAIT: begin
        if (rd_ready) begin
          mismatch_next = mismatch_reg || (rd_data != expected_word);
          index_next    = index_reg + IDX_W'(1);
          state_next    = (index_reg < LAST_IDX) ? RD_REQ : CHECK;
        end
      end
      CHECK: begin
        check_policy_next = !mismatch_reg;
        check_false_next  = mismatch_reg;
        state_next        = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign check_policy       = check_policy_reg;
  assign check_false_policy = check_false_reg;

endmodule

// File: tb/tb_wrap.sv
// Directed bench for wrap: a transaction-level model predicts both check
// outputs every cycle; literal checks pin key instants of each scenario.
module tb_wrap;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'hC0DE_0000;

  logic asclk = 1'b0;
  logic aresetn, start_w, start_r;
  logic check_policy, check_false_policy;

  wrap #(.N_ENTRIES(N), .POLICY_BASE(BASE)) dut (
    .asclk              (asclk),
    .aresetn            (aresetn),
    .start_w            (start_w),
    .start_r            (start_r),
    .check_policy       (check_policy),
    .check_false_policy (check_false_policy)
  );

  always #5 asclk = ~asclk;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  // Model: a request is honoured only when no operation is in flight; a write
  // occupies 2N cycles and fills the table, a read occupies 2N+1 cycles and
  // then publishes whether every entry equals BASE + i.
  logic [31:0] m_mem [N];
  bit m_armed = 0, m_prev_w = 0, m_prev_r = 0, m_is_read = 0;
  bit exp_pol = 0, exp_false = 0;
  int m_busy = 0;

  function automatic bit table_ok();
    bit ok = 1'b1;
    for (int i = 0; i < N; i++) if (m_mem[i] != BASE + 32'(i)) ok = 1'b0;
    return ok;
  endfunction

  always @(posedge asclk or negedge aresetn) begin
    if (!aresetn) begin
      m_armed = 0; m_prev_w = 0; m_prev_r = 0; m_busy = 0; m_is_read = 0;
      exp_pol = 0; exp_false = 0;
      for (int i = 0; i < N; i++) m_mem[i] = '0;
    end else begin
      bit ew, er;
      ew = m_armed && start_w && !m_prev_w;
      er = m_armed && start_r && !m_prev_r;
      m_prev_w = start_w;
      m_prev_r = start_r;
      m_armed  = 1'b1;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          if (m_is_read) begin
            exp_pol   = table_ok();
            exp_false = !table_ok();
          end else begin
            for (int i = 0; i < N; i++) m_mem[i] = BASE + 32'(i);
          end
        end
      end else if (ew || er) begin
        exp_pol   = 0;
        exp_false = 0;
        m_is_read = !ew;
        m_busy    = ew ? 2 * N : 2 * N + 1;
      end
    end
  end

  int n_rises = 0;
  bit prev_any = 0;

  always @(negedge asclk) begin
    if (cmp_en) begin
      tests++;
      if (check_policy !== exp_pol) begin
        fails++;
        $display("FAIL cyc_check_policy t=%0t got=%b exp=%b", $time, check_policy, exp_pol);
      end
      tests++;
      if (check_false_policy !== exp_false) begin
        fails++;
        $display("FAIL cyc_check_false_policy t=%0t got=%b exp=%b", $time, check_false_policy, exp_false);
      end
      if ((check_policy || check_false_policy) && !prev_any) n_rises++;
      prev_any = check_policy || check_false_policy;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge asclk);
  endtask

  task automatic outs(input string name, input logic p, input logic f);
    chk({name, "_pol"}, 32'(check_policy), 32'(p));
    chk({name, "_false"}, 32'(check_false_policy), 32'(f));
    $display("[TB] txn %s pol=%b false=%b", name, check_policy, check_false_policy);
  endtask

  int pat [4] = '{2, 2, 4, 4};
  int rises_before;

  initial begin
    aresetn = 0; start_w = 0; start_r = 0;
    cyc(3);
    cmp_en = 1;
    outs("reset", 0, 0);
    aresetn = 1;
    cyc(3);

    // Read with nothing written: table is all zero.
    start_r = 1;
    cyc(2 * N + 1); outs("rd_nowr_busy", 0, 0);
    cyc(1);         outs("rd_nowr_done", 0, 1);
    chk("model_rd_nowr", 32'(exp_false), 32'd1);
    start_r = 0; cyc(2);

    // Write pulse, then read; result exactly 2N+2 cycles after the read edge.
    start_w = 1; cyc(2); start_w = 0;
    outs("wr_clear", 0, 0);
    cyc(2 * N);
    start_r = 1;
    cyc(2 * N + 1); outs("rd_ok_early", 0, 0);
    cyc(1);         outs("rd_ok_done", 1, 0);
    chk("model_rd_ok", 32'(exp_pol), 32'd1);
    start_r = 0; cyc(2);

    // start_w toggling inside a burst must not start a second one.
    for (int k = 0; k < 4; k++) begin
      start_w = (k % 2 == 0);
      cyc(pat[k]);
      if (k == 0) outs("toggle_clear", 0, 0);
    end
    start_w = 0;
    start_r = 1; cyc(2 * N + 2); outs("toggle_rd", 1, 0);
    start_r = 0; cyc(2);

    // Simultaneous edges: write only, no check result.
    start_w = 1; start_r = 1;
    cyc(2 * N + 3); outs("both_edge", 0, 0);
    start_w = 0; start_r = 0; cyc(2);
    start_r = 1; cyc(2 * N + 2); outs("both_later_rd", 1, 0);
    start_r = 0; cyc(2);

    // Reset mid-burst with start_w still high across release.
    start_w = 1; cyc(3);
    aresetn = 0; cyc(1); outs("mid_rst", 0, 0);
    aresetn = 1; cyc(4);
    outs("post_rst_held", 0, 0);
    start_w = 0; cyc(2);
    start_r = 1; cyc(2 * N + 2); outs("post_rst_rd", 0, 1);
    start_r = 0; cyc(2);

    // Long start_r hold: exactly two checks, both passing.
    start_w = 1; cyc(2); start_w = 0; cyc(2 * N + 1);
    rises_before = n_rises;
    start_r = 1; cyc(25);
    outs("hold_first", 1, 0);
    start_r = 0; cyc(2);
    start_r = 1; cyc(1); outs("hold_cleared", 0, 0);
    cyc(2 * N + 3);
    start_r = 0;
    outs("hold_second", 1, 0);
    chk("hold_check_count", 32'(n_rises - rises_before), 32'd2);
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wrap.md
WRAP -- requirements
Module: wrap

Interface
REQ-001 Parameter N_ENTRIES, default 4, number of 32-bit policy entries held internally.
REQ-002 Parameter POLICY_BASE, default 32'hC0DE_0000, base of the expected policy pattern; entry i holds POLICY_BASE + i.
REQ-003 asclk  input  1  single clock; all logic on rising edge.
REQ-004 aresetn  input  1  reset, asynchronous, active-low.
REQ-005 start_w  input  1  level request; rising edge starts a policy write burst.
REQ-006 start_r  input  1  level request; rising edge starts a read-back and check.
REQ-007 check_policy  output  1  high after a completed check in which all entries matched.
REQ-008 check_false_policy  output  1  high after a completed check in which any entry mismatched.

Function
REQ-009 start_w and start_r SHALL each be registered once; a start is an edge where the registered value is 0 and the current value is 1. Held-high levels SHALL NOT retrigger.
REQ-010 Controller FSM states SHALL be IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK.
REQ-011 Starts SHALL be accepted only in IDLE; edges arriving in any other state SHALL be discarded, not queued.
REQ-012 If start_w and start_r edges occur in the same cycle, the write SHALL be taken and the read discarded.
REQ-013 Accepting any start SHALL clear both check outputs in the next cycle and load entry index 0.
REQ-014 WR_REQ SHALL assert wr_valid with address = index and data = POLICY_BASE + index, then go to WR_WAIT.
REQ-015 WR_WAIT SHALL hold wr_valid/address/data stable until wr_ready; on handshake, increment index; go to WR_REQ if index < N_ENTRIES-1, else IDLE.
REQ-016 Register file SHALL assert wr_ready exactly one cycle after wr_valid rises and SHALL update the entry on the handshake cycle; a full write burst SHALL take 2*N_ENTRIES cycles after acceptance.
REQ-017 RD_REQ SHALL assert rd_valid with address = index; register file SHALL return rd_data with rd_ready one cycle later; RD_WAIT SHALL compare rd_data with POLICY_BASE + index on the handshake cycle and accumulate a sticky mismatch flag.
REQ-018 After the last entry the FSM SHALL enter CHECK for one cycle, then IDLE.
REQ-019 In CHECK: check_policy <= ~mismatch, check_false_policy <= mismatch; exactly one SHALL be high.
REQ-020 Both outputs SHALL be registered and held until the next accepted start (REQ-013).
REQ-021 A read with no prior completed write SHALL compare against reset contents (all zero) and SHALL raise check_false_policy.
REQ-022 Index SHALL be log2(N_ENTRIES) bits wide; comparisons and POLICY_BASE + index SHALL be 32-bit unsigned, no overflow handling needed for default values.

Reset
REQ-023 While aresetn = 0: FSM = IDLE, index = 0, mismatch = 0, edge registers = 0, wr/rd handshake signals = 0, all entries = 0, check_policy = 0, check_false_policy = 0.
REQ-024 Reset asserted mid-burst SHALL abort immediately; after release, entries read as zero until a new full write completes.
REQ-025 Start levels already high when aresetn releases SHALL NOT count as edges.

Structure
REQ-026 FSM state encoding, DATA_W = 32, N_ENTRIES and POLICY_BASE defaults SHALL live in shared package wrap_pkg.
REQ-027 The register file with its valid/ready ports SHALL be a sub-module named policy_regs; wrap holds edge detection, FSM, comparison and outputs.

Verification
REQ-028 Reset, start_r rising with no write -> after read burst both low then check_false_policy = 1, check_policy = 0.
REQ-029 Reset, start_w pulse 2 cycles, wait idle, start_r rising -> check_policy = 1 at 2*N_ENTRIES+2 cycles after read edge detection, check_false_policy = 0.
REQ-030 start_w toggled 1/0/1 in 2- and 4-cycle steps during a burst -> edges inside burst ignored; single completed burst, later read passes.
REQ-031 start_w and start_r rising same cycle -> write only; outputs cleared, no check result until a later start_r.
REQ-032 aresetn pulsed low during write burst -> all outputs 0; subsequent start_r -> check_false_policy = 1.
REQ-033 start_r held high 25 cycles, dropped 2 cycles, raised again -> exactly two checks, both report same result, outputs cleared between them.
